// File: rtl/mul_arbiter_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter and its round-robin picker.
package mul_arb_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int W_DEF        = 16;
    localparam int MAX_WAIT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Width needed to hold values 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester handshake bus plus the port group toward the shared multiplier core.
interface mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*W-1:0]    rsp_data;
    logic              rsp_err;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_start;
    logic [2*W-1:0]    mul_out;
    logic              mul_done;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_out, mul_done,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mul_a, mul_b, mul_start
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_out, mul_done,
        output req_ready, rsp_valid, rsp_data, rsp_err, mul_a, mul_b, mul_start
    );
endinterface

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, wrapping.
module rr_pick
    import mul_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]                req,
    input  logic [idx_width(NREQ)-1:0]     ptr,
    output logic [idx_width(NREQ)-1:0]     sel,
    output logic                           any
);
    localparam int IDW = idx_width(NREQ);

    logic [IDW-1:0] idx;

    // Scan from the farthest offset back toward ptr so the nearest requester wins.
    always_comb begin
        sel = '0;
        idx = '0;
        any = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (req[idx]) sel = idx;
        end
    end
endmodule

// File: rtl/mul_arbiter.sv
// Shares one multi-cycle multiplier core among NREQ requesters with round-robin grants
// and a watchdog that answers with an error when the core never reports done.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int W        = W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    mul_arbiter_if.slave bus
);
    localparam int IDW = idx_width(NREQ);
    localparam int CW  = idx_width(MAX_WAIT + 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_RESP  = RESP;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] sel;
    logic           any;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   mul_a_q;
    logic [W-1:0]   mul_b_q;
    logic [2*W-1:0] rsp_data_q;
    logic           rsp_err_q;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr),
        .sel (sel),
        .any (any)
    );

    // Handshake strobes are suppressed while reset is high so no transfer completes in that cycle.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (!reset && state == S_IDLE && any) bus.req_ready[sel] = 1'b1;
        if (!reset && state == S_RESP)        bus.rsp_valid[id]  = 1'b1;
    end

    assign bus.mul_start = (state == S_START);
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    // Done on the same cycle the counter hits the limit takes priority over the timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            id         <= '0;
            cnt        <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any) begin
                        mul_a_q <= bus.req_a[sel*W +: W];
                        mul_b_q <= bus.req_b[sel*W +: W];
                        id      <= sel;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mul_done) begin
                        rsp_data_q <= bus.mul_out;
                        rsp_err_q  <= 1'b0;
                        state      <= S_RESP;
                    end else if (cnt == CW'(MAX_WAIT)) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready[id]) begin
                        ptr   <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of grant order, product and latency.
module tb_mul_arbiter;
    localparam int NREQ     = 4;
    localparam int W        = 16;
    localparam int MAX_WAIT = 15;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mul_arbiter_if #(.NREQ(NREQ), .W(W)) bus();

    mul_arbiter #(.NREQ(NREQ), .W(W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Core model: done pulses core_lat cycles after the start pulse, unless disabled.
    int           core_lat   = 4;
    bit           core_on    = 1'b1;
    int           stray_req  = 0;
    int           stray_ack  = 0;
    int           cd         = 0;
    logic [W-1:0] ca         = '0;
    logic [W-1:0] cb         = '0;

    always @(negedge clk) begin
        bus.mul_done = 1'b0;
        bus.mul_out  = '0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0 && core_on) begin
                bus.mul_done = 1'b1;
                bus.mul_out  = (2*W)'(ca) * (2*W)'(cb);
            end
        end
        if (stray_req != stray_ack) begin
            bus.mul_done = 1'b1;
            bus.mul_out  = 32'hDEAD_BEEF;
            stray_ack    = stray_req;
        end
        if (bus.mul_start === 1'b1) begin
            cd = core_lat;
            ca = bus.mul_a;
            cb = bus.mul_b;
        end
    end

    int           ptr_m = 0;
    logic [W-1:0] opa [NREQ];
    logic [W-1:0] opb [NREQ];

    function automatic int pickModel(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic applyStimulus(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] rready);
        bus.req_valid = mask;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = opa[i];
            bus.req_b[i*W +: W] = opb[i];
        end
        bus.rsp_ready = rready;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction from an IDLE negedge back to the next IDLE negedge.
    task automatic runTxn(input logic [NREQ-1:0] mask, input int hold, input int lat,
                          input bit on, input bit stray, output int acc);
        int             g;
        int             exp_lat;
        int             t0;
        bit             seen;
        bit             exp_err;
        logic [2*W-1:0] exp_data;
        core_lat = lat;
        core_on  = on;
        applyStimulus(mask, '0);
        #1;
        g = pickModel(mask, ptr_m);
        checkOutput("req_ready_grant", bus.req_ready, onehot(g));
        t0  = cyc;
        acc = t0;
        exp_data = (2*W)'(opa[g]) * (2*W)'(opb[g]);
        exp_err  = 1'b0;
        exp_lat  = 2 + lat;
        if (!on || lat > MAX_WAIT + 1) begin
            exp_data = '0;
            exp_err  = 1'b1;
            exp_lat  = 3 + MAX_WAIT;
        end
        @(negedge clk);
        checkOutput("mul_start", bus.mul_start, 1);
        checkOutput("mul_a", bus.mul_a, opa[g]);
        checkOutput("mul_b", bus.mul_b, opb[g]);
        checkOutput("req_ready_start", bus.req_ready, 0);
        opa[g] = W'($urandom);
        opb[g] = W'($urandom);
        applyStimulus(mask, '0);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus.rsp_valid !== '0) seen = 1'b1;
        end
        checkOutput("rsp_seen", seen, 1);
        if (!seen) begin
            applyStimulus('0, '0);
            return;
        end
        checkOutput("rsp_latency", cyc - t0, exp_lat);
        checkOutput("rsp_valid", bus.rsp_valid, onehot(g));
        checkOutput("rsp_data", bus.rsp_data, exp_data);
        checkOutput("rsp_err", bus.rsp_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            applyStimulus(mask, ~onehot(g));
            if (stray && h == 0) stray_req++;
            @(negedge clk);
            checkOutput("hold_rsp_valid", bus.rsp_valid, onehot(g));
            checkOutput("hold_rsp_data", bus.rsp_data, exp_data);
            checkOutput("hold_rsp_err", bus.rsp_err, exp_err);
            checkOutput("hold_req_ready", bus.req_ready, 0);
        end
        applyStimulus(mask, onehot(g));
        @(negedge clk);
        ptr_m = (g + 1) % NREQ;
        applyStimulus('0, '0);
        checkOutput("rsp_released", bus.rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int               t;
        int               prev;
        int               g;
        logic [NREQ-1:0]  mask;

        for (int i = 0; i < NREQ; i++) begin
            opa[i] = W'($urandom);
            opb[i] = W'($urandom);
        end
        reset = 1'b1;
        applyStimulus('0, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_req_ready", bus.req_ready, 0);
        checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
        checkOutput("reset_rsp_data", bus.rsp_data, 0);
        checkOutput("reset_rsp_err", bus.rsp_err, 0);
        checkOutput("reset_mul_a", bus.mul_a, 0);
        checkOutput("reset_mul_b", bus.mul_b, 0);
        checkOutput("reset_mul_start", bus.mul_start, 0);

        $display("[TB] single request");
        opa[0] = 16'h1234;
        opb[0] = 16'h5678;
        runTxn(4'b0001, 0, 4, 1'b1, 1'b0, t);

        $display("[TB] max operands on requester 3, then wrap to 0");
        opa[3] = 16'hFFFF;
        opb[3] = 16'hFFFF;
        runTxn(4'b1000, 0, 4, 1'b1, 1'b0, t);
        checkOutput("ptr_after_wrap", ptr_m, 0);

        $display("[TB] round-robin with all requesters valid");
        runTxn(4'b1111, 0, 4, 1'b1, 1'b0, prev);
        for (int k = 0; k < 3; k++) begin
            runTxn(4'b1111, 0, 4, 1'b1, 1'b0, t);
            checkOutput("accept_spacing", t - prev, 7);
            prev = t;
        end
        $display("[TB] requester 2 drops out");
        for (int k = 0; k < 4; k++) begin
            runTxn(4'b1011, 0, 4, 1'b1, 1'b0, t);
            checkOutput("accept_spacing_drop", t - prev, 7);
            prev = t;
        end

        $display("[TB] backpressure on requester 1");
        runTxn(4'b0010, 10, 4, 1'b1, 1'b0, t);
        runTxn(4'b0011, 10, 4, 1'b1, 1'b0, t);

        $display("[TB] timeout and late done");
        runTxn(4'b0100, 3, 4, 1'b0, 1'b1, t);
        runTxn(4'b0001, 2, MAX_WAIT + 1, 1'b1, 1'b0, t);
        runTxn(4'b0001, 2, MAX_WAIT + 2, 1'b1, 1'b0, t);

        $display("[TB] reset while waiting");
        runTxn(4'b0010, 0, 4, 1'b1, 1'b0, t);
        core_lat = 4;
        core_on  = 1'b1;
        opa[3]   = W'($urandom);
        opb[3]   = W'($urandom);
        applyStimulus(4'b1000, '0);
        #1;
        g = pickModel(4'b1000, ptr_m);
        checkOutput("rst_txn_grant", bus.req_ready, onehot(g));
        @(negedge clk);
        applyStimulus('0, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
        #1;
        checkOutput("rst_wait_rsp_valid", bus.rsp_valid, 0);
        checkOutput("rst_wait_rsp_data", bus.rsp_data, 0);
        checkOutput("rst_wait_rsp_err", bus.rsp_err, 0);
        checkOutput("rst_wait_mul_a", bus.mul_a, 0);
        checkOutput("rst_wait_mul_b", bus.mul_b, 0);
        checkOutput("rst_wait_mul_start", bus.mul_start, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("stray_done_rsp_valid", bus.rsp_valid, 0);
            checkOutput("stray_done_mul_start", bus.mul_start, 0);
        end
        runTxn(4'b0110, 0, 4, 1'b1, 1'b0, t);
        runTxn(4'b0100, 0, 4, 1'b1, 1'b0, t);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 16; k++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            runTxn(mask, $urandom_range(0, 3), $urandom_range(1, 8), 1'b1, 1'b0, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin scheduler that shares one multi-cycle 16x16 multiplier core among NREQ requesters inside the ECDSA field-arithmetic datapath. It accepts operand pairs over per-requester valid/ready handshakes, issues them one at a time to the core with a start pulse, and waits for the core's done. It then returns the 32-bit product to the granted requester, holding it until that requester accepts it. A watchdog returns an error response if the core never signals done.

## Interface
- NREQ, 4: number of requesters (2..8).
- W, 16: operand width; product width is 2W.
- MAX_WAIT, 15: cycles allowed in WAIT before timeout (>=5).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*W  operand A; requester i at [i*W +: W].
- req_b  in  NREQ*W  operand B; same packing.
- req_ready  out  NREQ  one-hot accept strobe, combinational.
- rsp_valid  out  NREQ  one-hot response valid.
- rsp_data  out  2W  product (0 on error).
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- rsp_ready  in  NREQ  per-requester response accept.
- mul_a, mul_b  out  W  operands to the core, registered, stable from START through WAIT.
- mul_start  out  1  single-cycle issue pulse.
- mul_out  in  2W  core product.
- mul_done  in  1  core completion.

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE
  - The round-robin picker selects the lowest valid index at or above ptr, wrapping modulo NREQ.
  - If any req_valid: req_ready[sel]=1 this cycle, latch req_a/req_b[sel] into mul_a/mul_b, latch id=sel, go to START.
- START: mul_start=1 for exactly one cycle, clear the wait counter, go to WAIT.
- WAIT
  - mul_done=1: capture mul_out into rsp_data, rsp_err=0, go to RESP.
  - Counter reaches MAX_WAIT without done: rsp_data=0, rsp_err=1, go to RESP.
  - mul_done is ignored in all states other than WAIT.
- RESP
  - rsp_valid[id]=1; rsp_data and rsp_err held stable.
  - On rsp_ready[id]=1: ptr=(id+1) mod NREQ, go to IDLE.
  - rsp_ready on any other index is ignored.
- req_ready is never asserted outside IDLE.
- A requester must hold req_valid and its operands until it sees req_ready.
- Requesters not granted keep waiting; a waiting requester is served within NREQ-1 grants.
- Simultaneous events:
  - mul_done in the same cycle as the timeout limit counts as done (no error).
  - reset together with any input: reset wins.
- Reset mid-operation: state=IDLE, ptr=0, id=0, counter=0. The core is not notified; its in-flight result is dropped because done is ignored outside WAIT.
- Reset values of outputs: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, mul_a=0, mul_b=0, mul_start=0.

## Timing
- Accept at cycle T (IDLE, req_ready=1).
- mul_start=1 at T+1.
- WAIT from T+2.
- Core done seen at cycle D gives rsp_valid from D+1.
- With a core reporting done 4 cycles after start: rsp_valid at T+6.
- Response accepted at cycle R gives IDLE at R+1, so the next accept can be at R+1.
- Minimum accept-to-accept spacing: 7 cycles with a 4-cycle core and immediate rsp_ready.
- Timeout: rsp_valid with rsp_err=1 at T+2+MAX_WAIT+1.

## Structure
- Package mul_arb_pkg holds:
  - the state enum (IDLE/START/WAIT/RESP);
  - default W, NREQ, MAX_WAIT;
  - a clog2-based width constant for id, ptr and the wait counter.
- Sub-module rr_pick (NREQ parameter): inputs req, ptr; outputs sel and any. Purely combinational, reused by other shared-resource arbiters in the datapath.
- The multiplier core is instantiated outside this block; only the mul_* ports connect to it.

## Test plan
- Single request: req 0, a=0x1234, b=0x5678, core model done 4 cycles after start -> rsp_valid[0] at T+6, rsp_data=0x06260060, rsp_err=0.
- Max operands: a=0xFFFF, b=0xFFFF on requester 3 -> rsp_data=0xFFFE0001; the next grant starts from requester 0.
- Round-robin fairness: all four requesters valid continuously -> grants in order 0,1,2,3,0.
  - Requester 2 drops out -> order 0,1,3,0.
- Backpressure: hold rsp_ready[1]=0 for 10 cycles.
  - rsp_valid[1] and rsp_data stay stable.
  - req_ready stays 0.
  - rsp_ready[0]=1 during this window is ignored.
- Timeout: core never asserts done -> rsp_valid, rsp_err=1, rsp_data=0 exactly MAX_WAIT+1 cycles after entering WAIT; a done arriving afterwards has no effect.
- Reset in WAIT:
  - Assert reset for one cycle -> all outputs 0, ptr=0.
  - A stray mul_done next cycle produces no response.
  - A new request on index 2 is granted normally.
